// File: rtl/pwm_ctrl_pkg.sv
// Shared constants and types for the PWM configuration/sweep controller.
package pwm_ctrl_pkg;

    localparam logic [1:0] ADDR_DUTY  = 2'd0;
    localparam logic [1:0] ADDR_PHASE = 2'd1;
    localparam logic [1:0] ADDR_STEP  = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    localparam int CTRL_SWEEP_EN  = 0;
    localparam int CTRL_TRI       = 1;
    localparam int CTRL_DWELL_LSB = 2;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

endpackage

// File: rtl/pwm_sweep_step.sv
// Next duty and direction for one sweep update (sawtooth wrap or triangle saturate).
module pwm_sweep_step #(
    parameter int W = 7
) (
    input  logic [W-1:0] duty,
    input  logic [W-1:0] step,
    input  logic         dir_down,
    input  logic         tri_mode,
    output logic [W-1:0] duty_nxt,
    output logic         dir_down_nxt
);

    localparam logic [W:0] DUTY_MAX = {1'b0, {W{1'b1}}};

    logic [W:0] sum;

    assign sum = {1'b0, duty} + {1'b0, step};

    always_comb begin
        duty_nxt     = sum[W-1:0];
        dir_down_nxt = dir_down;
        if (tri_mode) begin
            if (!dir_down) begin
                if (sum >= DUTY_MAX) begin
                    duty_nxt     = {W{1'b1}};
                    dir_down_nxt = 1'b1;
                end
            end else if (duty <= step) begin
                duty_nxt     = '0;
                dir_down_nxt = 1'b0;
            end else begin
                duty_nxt = duty - step;
            end
        end
    end

endmodule

// File: rtl/pwm_sweep_ctrl.sv
// PWM configuration controller: shadowed writes committed at the period boundary,
// with optional automatic duty sweep.
module pwm_sweep_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int W       = 7,
    parameter int DWELL_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [1:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    output logic [W-1:0] PWMDuty,
    output logic [W-1:0] phase,
    output logic         period_start,
    output logic         pending
);

    logic [W-1:0]       cnt;
    logic [W-1:0]       sh_duty, sh_phase, sh_step, sh_ctrl;
    logic [W-1:0]       step, ctrl;
    logic [3:0]         dirty;
    logic               dir_down;
    logic [DWELL_W-1:0] dwell_cnt;
    state_t             state, state_nxt;

    logic               boundary, accept, commit;
    logic               sweep_en, tri_mode, sweep_due;
    logic [DWELL_W-1:0] dwell_m1;
    logic [W-1:0]       sweep_duty;
    logic               sweep_dir_down;

    assign boundary     = (cnt == {W{1'b1}});
    assign cfg_ready    = !reset && !boundary;
    assign accept       = cfg_valid && cfg_ready;
    assign period_start = !reset && (cnt == '0);

    assign sweep_en  = ctrl[CTRL_SWEEP_EN];
    assign tri_mode  = ctrl[CTRL_TRI];
    assign dwell_m1  = ctrl[CTRL_DWELL_LSB +: DWELL_W];
    assign sweep_due = sweep_en && (dwell_cnt == dwell_m1);

    pwm_sweep_step #(.W(W)) u_step (
        .duty         (PWMDuty),
        .step         (step),
        .dir_down     (dir_down),
        .tri_mode     (tri_mode),
        .duty_nxt     (sweep_duty),
        .dir_down_nxt (sweep_dir_down)
    );

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept)   state_nxt = ST_PENDING;
            ST_PENDING: if (boundary) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pending = (state == ST_PENDING);
        commit  = pending && boundary;
    end

    // Writes are refused in the boundary cycle, so accept and clear never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_duty  <= '0;
            sh_phase <= '0;
            sh_step  <= W'(1);
            sh_ctrl  <= '0;
            dirty    <= '0;
        end else begin
            if (boundary) dirty <= '0;
            if (accept) begin
                dirty[cfg_addr] <= 1'b1;
                case (cfg_addr)
                    ADDR_DUTY:  sh_duty  <= cfg_data;
                    ADDR_PHASE: sh_phase <= cfg_data;
                    ADDR_STEP:  sh_step  <= cfg_data;
                    default:    sh_ctrl  <= cfg_data;
                endcase
            end
        end
    end

    // A control or duty commit overrides any sweep update due at the same boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            PWMDuty   <= '0;
            phase     <= '0;
            step      <= W'(1);
            ctrl      <= '0;
            dir_down  <= 1'b0;
            dwell_cnt <= '0;
        end else if (boundary) begin
            if (commit && dirty[ADDR_PHASE]) phase <= sh_phase;
            if (commit && dirty[ADDR_STEP])  step  <= sh_step;
            if (commit && dirty[ADDR_CTRL]) begin
                ctrl      <= sh_ctrl;
                dir_down  <= 1'b0;
                dwell_cnt <= '0;
            end
            if (commit && dirty[ADDR_DUTY]) begin
                PWMDuty   <= sh_duty;
                dwell_cnt <= '0;
            end else if (!(commit && dirty[ADDR_CTRL]) && sweep_en) begin
                if (sweep_due) begin
                    PWMDuty   <= sweep_duty;
                    dir_down  <= sweep_dir_down;
                    dwell_cnt <= '0;
                end else begin
                    dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_sweep_ctrl.sv
// Directed bench for pwm_sweep_ctrl: commit timing, boundary write refusal, sweeps, reset.
module tb_pwm_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_addr = 2'd0;
    logic [6:0] cfg_data = 7'd0;
    logic [6:0] PWMDuty;
    logic [6:0] phase;
    logic       period_start;
    logic       pending;

    int n_chk = 0;
    int n_err = 0;
    int tb_cnt = 0;
    bit live = 1'b0;

    int saw_exp [3]  = '{50, 100, 22};
    int tri_exp [15] = '{0, 0, 50, 50, 100, 100, 127, 127, 77, 77, 27, 27, 0, 0, 50};

    pwm_sweep_ctrl #(.W(7), .DWELL_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .PWMDuty      (PWMDuty),
        .phase        (phase),
        .period_start (period_start),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cnt=%0d)", tag, got, exp, tb_cnt);
        end
    endtask

    // Advance one cycle; outside reset, period_start and cfg_ready follow the period count.
    task automatic tick();
        @(negedge clk);
        if (live) begin
            tb_cnt = (tb_cnt + 1) % 128;
            check("period_start", 32'(period_start), 32'(tb_cnt == 0));
            check("cfg_ready", 32'(cfg_ready), 32'(tb_cnt != 127));
        end
    endtask

    task automatic goto(input int c);
        while (tb_cnt != c) tick();
    endtask

    task automatic nextper();
        tick();
        goto(0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [6:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        check("wr_ready", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
        tb_cnt = 0;
        live   = 1'b1;
        check("rel_period_start", 32'(period_start), 32'd1);
        check("rel_cfg_ready", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_duty", 32'(PWMDuty), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_pstart", 32'(period_start), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        release_reset();

        // Shadowed duty writes, last one wins
        goto(10);
        wr(2'd0, 7'd40);
        check("pend_after_wr", 32'(pending), 32'd1);
        goto(20);
        wr(2'd0, 7'd64);
        check("duty_held", 32'(PWMDuty), 32'd0);
        goto(127);
        check("duty_held_bnd", 32'(PWMDuty), 32'd0);
        check("pend_bnd", 32'(pending), 32'd1);
        tick();
        check("duty_commit", 32'(PWMDuty), 32'd64);
        check("pend_clear", 32'(pending), 32'd0);

        // Write held across the boundary cycle
        goto(127);
        cfg_valid = 1'b1;
        cfg_addr  = 2'd1;
        cfg_data  = 7'd33;
        check("bnd_ready", 32'(cfg_ready), 32'd0);
        tick();
        check("bnd_not_taken", 32'(pending), 32'd0);
        tick();
        cfg_valid = 1'b0;
        check("bnd_taken", 32'(pending), 32'd1);
        check("phase_held", 32'(phase), 32'd0);
        goto(127);
        check("phase_held_bnd", 32'(phase), 32'd0);
        tick();
        check("phase_commit", 32'(phase), 32'd33);

        // Sawtooth, step 50, dwell 1
        wr(2'd2, 7'd50);
        wr(2'd3, 7'd1);
        wr(2'd0, 7'd0);
        nextper();
        check("saw_b0", 32'(PWMDuty), 32'd0);
        for (int i = 0; i < 3; i++) begin
            nextper();
            check($sformatf("saw_b%0d", i + 1), 32'(PWMDuty), 32'(saw_exp[i]));
        end
        goto(64);
        check("saw_mid", 32'(PWMDuty), 32'd22);

        // Triangle, step 50, dwell 2
        wr(2'd3, 7'd7);
        wr(2'd0, 7'd0);
        for (int i = 0; i < 15; i++) begin
            nextper();
            check($sformatf("tri_b%0d", i), 32'(PWMDuty), 32'(tri_exp[i]));
        end
        nextper();
        check("tri_b15", 32'(PWMDuty), 32'd50);

        // Duty commit on a sweep-update boundary restarts dwell
        wr(2'd0, 7'd10);
        nextper();
        check("ovr_b16", 32'(PWMDuty), 32'd10);
        nextper();
        check("ovr_b17", 32'(PWMDuty), 32'd10);
        nextper();
        check("ovr_b18", 32'(PWMDuty), 32'd60);

        // Reset while a write is pending
        goto(40);
        wr(2'd1, 7'd99);
        check("pend_pre_rst", 32'(pending), 32'd1);
        reset = 1'b1;
        live  = 1'b0;
        tick();
        tick();
        check("mid_rst_ready", 32'(cfg_ready), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'd0);
        check("mid_rst_duty", 32'(PWMDuty), 32'd0);
        check("mid_rst_phase", 32'(phase), 32'd0);
        check("mid_rst_pstart", 32'(period_start), 32'd0);
        release_reset();
        goto(127);
        tick();
        check("lost_phase", 32'(phase), 32'd0);
        check("lost_duty", 32'(PWMDuty), 32'd0);
        check("lost_pending", 32'(pending), 32'd0);
        nextper();
        check("no_sweep_duty", 32'(PWMDuty), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
